// File: rtl/csr_counter.sv
// -----------------------------------------------------------------------------
// csr_counter
//
// Machine performance-counter file: the 64-bit cycle counter (mcycle), the
// 64-bit retired-instruction counter (minstret) and the two implemented
// mcountinhibit bits (CY = bit0, IR = bit2). The full counters feed the CSR
// read-select logic directly; a 32-bit combinational read port serves the
// five mapped CSR addresses. CSR writes arrive already qualified from EX.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous, active-high reset
//   retire_valid  a valid, non-bubble instruction leaves WB this cycle
//   stall         pipeline stall; retirement is not counted while high
//   wr_en         CSR write strobe (already qualified)
//   wr_addr       CSR address of the write
//   wr_data       final 32-bit value to write
//   rd_addr       CSR address for the read port
//   rd_data       combinational read of the addressed register, 0 if unmapped
//   rd_hit        rd_addr is one of the five mapped addresses
//   Cycle         current cycle count (registered)
//   Instructions  current retired-instruction count (registered)
// -----------------------------------------------------------------------------
module csr_counter #(
    parameter logic [63:0] CYCLE_RST   = 64'd0,
    parameter logic [63:0] INSTRET_RST = 64'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        retire_valid,
    input  logic        stall,
    input  logic        wr_en,
    input  logic [11:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic [11:0] rd_addr,
    output logic [31:0] rd_data,
    output logic        rd_hit,
    output logic [63:0] Cycle,
    output logic [63:0] Instructions
);

    localparam logic [11:0] ADDR_MCYCLE     = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH    = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET   = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH  = 12'hB82;
    localparam logic [11:0] ADDR_MCOUNTINH  = 12'h320;

    // 64-bit increment built as two 32-bit halves with an explicit carry,
    // so the low-to-high carry path is visible; all-ones wraps to zero.
    function automatic logic [63:0] f_inc64(input logic [63:0] v);
        logic [32:0] lo;
        logic [31:0] hi;
        lo = {1'b0, v[31:0]} + 33'd1;
        hi = v[63:32] + {31'd0, lo[32]};
        return {hi, lo[31:0]};
    endfunction

    // Next value of one counter. A write to either half takes priority over
    // the increment and leaves the other half untouched, so a high-half write
    // never sees a carry out of the low half.
    function automatic logic [63:0] f_next(
        input logic [63:0] cur,
        input logic        wr_lo,
        input logic        wr_hi,
        input logic        inc,
        input logic [31:0] data
    );
        logic [63:0] nxt;
        if (wr_lo)
            nxt = {cur[63:32], data};
        else if (wr_hi)
            nxt = {data, cur[31:0]};
        else if (inc)
            nxt = f_inc64(cur);
        else
            nxt = cur;
        return nxt;
    endfunction

    logic [63:0] r_cycle;
    logic [63:0] r_instret;
    logic        r_inh_cy;
    logic        r_inh_ir;

    logic        w_wr_cyc_lo;
    logic        w_wr_cyc_hi;
    logic        w_wr_ins_lo;
    logic        w_wr_ins_hi;
    logic        w_wr_inh;
    logic        w_cycle_inc;
    logic        w_instret_inc;
    logic [63:0] w_cycle_next;
    logic [63:0] w_instret_next;

    assign w_wr_cyc_lo = wr_en && (wr_addr == ADDR_MCYCLE);
    assign w_wr_cyc_hi = wr_en && (wr_addr == ADDR_MCYCLEH);
    assign w_wr_ins_lo = wr_en && (wr_addr == ADDR_MINSTRET);
    assign w_wr_ins_hi = wr_en && (wr_addr == ADDR_MINSTRETH);
    assign w_wr_inh    = wr_en && (wr_addr == ADDR_MCOUNTINH);

    // Increments use the currently stored inhibit bits; a write to
    // mcountinhibit only affects counting from the following cycle.
    assign w_cycle_inc   = ~r_inh_cy;
    assign w_instret_inc = retire_valid & ~stall & ~r_inh_ir;

    assign w_cycle_next   = f_next(r_cycle,   w_wr_cyc_lo, w_wr_cyc_hi,
                                   w_cycle_inc, wr_data);
    assign w_instret_next = f_next(r_instret, w_wr_ins_lo, w_wr_ins_hi,
                                   w_instret_inc, wr_data);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle   <= CYCLE_RST;
            r_instret <= INSTRET_RST;
            r_inh_cy  <= 1'b0;
            r_inh_ir  <= 1'b0;
        end else begin
            r_cycle   <= w_cycle_next;
            r_instret <= w_instret_next;
            if (w_wr_inh) begin
                r_inh_cy <= wr_data[0];
                r_inh_ir <= wr_data[2];
            end
        end
    end

    assign Cycle        = r_cycle;
    assign Instructions = r_instret;

    // Read port reflects registered state only; same-cycle writes are not
    // forwarded.
    always_comb begin
        rd_data = 32'd0;
        rd_hit  = 1'b0;
        case (rd_addr)
            ADDR_MCYCLE: begin
                rd_data = r_cycle[31:0];
                rd_hit  = 1'b1;
            end
            ADDR_MCYCLEH: begin
                rd_data = r_cycle[63:32];
                rd_hit  = 1'b1;
            end
            ADDR_MINSTRET: begin
                rd_data = r_instret[31:0];
                rd_hit  = 1'b1;
            end
            ADDR_MINSTRETH: begin
                rd_data = r_instret[63:32];
                rd_hit  = 1'b1;
            end
            ADDR_MCOUNTINH: begin
                rd_data = {29'd0, r_inh_ir, 1'b0, r_inh_cy};
                rd_hit  = 1'b1;
            end
            default: begin
                rd_data = 32'd0;
                rd_hit  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_csr_counter.sv
// -----------------------------------------------------------------------------
// tb_csr_counter
//
// Directed bench for csr_counter: a linear sequence of stimulus steps with
// hand-computed expected values checked by immediate assertions.
// -----------------------------------------------------------------------------
module tb_csr_counter;

    logic        clk;
    logic        rst;
    logic        retire_valid;
    logic        stall;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    logic [11:0] rd_addr;
    logic [31:0] rd_data;
    logic        rd_hit;
    logic [63:0] Cycle;
    logic [63:0] Instructions;

    int checks   = 0;
    int failures = 0;

    csr_counter #(
        .CYCLE_RST   (64'd0),
        .INSTRET_RST (64'd0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .retire_valid (retire_valid),
        .stall        (stall),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_hit       (rd_hit),
        .Cycle        (Cycle),
        .Instructions (Instructions)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write(input logic [11:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
    endtask

    initial begin
        rst          = 1'b1;
        retire_valid = 1'b0;
        stall        = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = 12'h000;
        wr_data      = 32'd0;
        rd_addr      = 12'hB00;

        // Reset state, before any clock edge
        #2;
        check("rst_cycle",   Cycle, 64'd0);
        check("rst_instret", Instructions, 64'd0);
        check("rst_rd_data", {32'd0, rd_data}, 64'd0);
        check("rst_rd_hit",  {63'd0, rd_hit}, 64'd1);

        // Release between edges, then 10 free clocks
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("free_cycle",   Cycle, 64'd10);
        check("free_instret", Instructions, 64'd0);
        check("free_rd_data", {32'd0, rd_data}, 64'd10);
        check("free_rd_hit",  {63'd0, rd_hit}, 64'd1);

        // 5 retiring cycles, 2 of them stalled -> +3
        retire_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            stall = (i == 1 || i == 3);
            tick();
        end
        stall = 1'b0;
        check("retire_instret", Instructions, 64'd3);
        check("retire_cycle",   Cycle, 64'd15);

        // minstret low write while retiring: write wins, no forwarding
        write(12'hB02, 32'h100);
        rd_addr = 12'hB02;
        #1;
        check("nofwd_rd_data", {32'd0, rd_data}, 64'd3);
        tick();
        check("wr_instret_lo", Instructions, 64'h100);
        check("wr_other_cycle", Cycle, 64'd16);
        check("rd_instret_lo", {32'd0, rd_data}, 64'h100);

        // minstret high write while retiring: low half held
        write(12'hB82, 32'hA);
        tick();
        check("wr_instret_hi", Instructions, 64'h0000000A_00000100);
        check("wr_hi_cycle",   Cycle, 64'd17);
        rd_addr = 12'hB82;
        #1;
        check("rd_instret_hi", {32'd0, rd_data}, 64'hA);
        wr_en        = 1'b0;
        retire_valid = 1'b0;

        // Carry from low into high half
        write(12'hB00, 32'hFFFF_FFFE);
        tick();
        check("carry_wr_lo", Cycle, 64'h00000000_FFFFFFFE);
        write(12'hB80, 32'h0);
        tick();
        check("carry_wr_hi", Cycle, 64'h00000000_FFFFFFFE);
        wr_en = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("carry_cycle", Cycle, 64'h00000001_00000001);
        rd_addr = 12'hB80;
        #1;
        check("carry_rd_hi", {32'd0, rd_data}, 64'd1);

        // All-ones wraps to zero
        write(12'hB00, 32'hFFFF_FFFF);
        tick();
        write(12'hB80, 32'hFFFF_FFFF);
        tick();
        check("preset_ones", Cycle, 64'hFFFFFFFF_FFFFFFFF);
        wr_en = 1'b0;
        tick();
        check("wrap_cycle", Cycle, 64'd0);
        check("wrap_instret", Instructions, 64'h0000000A_00000100);

        // Inhibit both counters; the write edge itself still counts
        write(12'h320, 32'h5);
        tick();
        check("inh_wr_cycle", Cycle, 64'd1);
        wr_en        = 1'b0;
        retire_valid = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("inh_cycle",   Cycle, 64'd1);
        check("inh_instret", Instructions, 64'h0000000A_00000100);
        rd_addr = 12'h320;
        #1;
        check("inh_rd", {32'd0, rd_data}, 64'h5);

        // Clear inhibit (unimplemented bits set, must read back 0)
        write(12'h320, 32'hFFFF_FFFA);
        tick();
        check("uninh_edge_cycle",   Cycle, 64'd1);
        check("uninh_edge_instret", Instructions, 64'h0000000A_00000100);
        check("uninh_rd", {32'd0, rd_data}, 64'h0);
        wr_en = 1'b0;
        tick();
        check("resume_cycle",   Cycle, 64'd2);
        check("resume_instret", Instructions, 64'h0000000A_00000101);

        // Asynchronous reset mid-count, between edges
        write(12'h320, 32'h1);
        tick();
        check("pre_rst_cycle", Cycle, 64'd3);
        wr_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_cycle",   Cycle, 64'd0);
        check("arst_instret", Instructions, 64'd0);
        check("arst_inh_rd",  {32'd0, rd_data}, 64'd0);
        rd_addr = 12'h123;
        #1;
        check("unmapped_hit",  {63'd0, rd_hit}, 64'd0);
        check("unmapped_data", {32'd0, rd_data}, 64'd0);
        tick();
        check("hold_rst_cycle", Cycle, 64'd0);

        // Leave reset; inhibit was cleared, so counting starts at once
        #2;
        rst          = 1'b0;
        retire_valid = 1'b0;
        tick();
        check("post_rst_cycle", Cycle, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
